// File: rtl/spi_bpl_poll_master.sv
// SPI mode-0 initiator for the backplane bus: one command byte {rw, adr},
// a turnaround gap, then an NBIT-bit full-duplex data phase.
module spi_bpl_poll_master #(
    parameter int NBIT     = 8,
    parameter int CLK_DIV  = 4,
    parameter int TURN_CYC = 8,
    parameter int CS_GAP   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [6:0]      adr,
    input  logic            rw,
    input  logic [NBIT-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic [NBIT-1:0] rdata,
    output logic            sclk,
    output logic            mosi,
    input  logic            miso,
    output logic            cs
);

    typedef enum logic [2:0] {IDLE, SETUP, ADDR, TURN, DATA, HOLD, GAP} state_t;

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0] TURN_LAST = 8'(TURN_CYC - 1);
    localparam logic [7:0] GAP_LAST  = 8'(CS_GAP - 1);
    localparam logic [4:0] ABIT_LAST = 5'd7;
    localparam logic [4:0] DBIT_LAST = 5'(NBIT - 1);

    state_t          state;
    logic [7:0]      cyc_cnt;
    logic [4:0]      bit_cnt;
    logic [7:0]      cmd_sr;
    logic            rw_q;
    logic [NBIT-1:0] wdata_sr;
    logic [NBIT-1:0] cap_sr;
    logic            miso_meta;
    logic            miso_sync;

    logic            half_end;
    logic [7:0]      cmd_shl;
    logic [NBIT-1:0] wdata_shl;
    logic [NBIT-1:0] cap_next;

    assign half_end  = (cyc_cnt == DIV_LAST);
    assign cmd_shl   = cmd_sr << 1;
    assign wdata_shl = wdata_sr << 1;
    assign cap_next  = (cap_sr << 1) | NBIT'(miso_sync);

    // miso idles high, so the synchronizer resets to the idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            miso_meta <= 1'b1;
            miso_sync <= 1'b1;
        end else begin
            miso_meta <= miso;
            miso_sync <= miso_meta;
        end
    end

    // NOTE: state registers use non-blocking assignments so every branch
    // below sees the pre-edge values of sclk, cyc_cnt and the shift registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cyc_cnt  <= '0;
            bit_cnt  <= '0;
            cmd_sr   <= '0;
            rw_q     <= 1'b0;
            wdata_sr <= '0;
            cap_sr   <= '0;
            rdata    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            cs       <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cmd_sr   <= {rw, adr};
                        rw_q     <= rw;
                        wdata_sr <= wdata;
                        mosi     <= rw;
                        cs       <= 1'b0;
                        busy     <= 1'b1;
                        cyc_cnt  <= '0;
                        state    <= SETUP;
                    end
                end

                SETUP: begin
                    if (half_end) begin
                        cyc_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= ADDR;
                    end else begin
                        cyc_cnt <= cyc_cnt + 8'd1;
                    end
                end

                // Each bit is a low half then a high half; mosi moves only as
                // sclk falls, so it is stable across the whole bit.
                ADDR: begin
                    if (!half_end) begin
                        cyc_cnt <= cyc_cnt + 8'd1;
                    end else begin
                        cyc_cnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            sclk <= 1'b0;
                            if (bit_cnt == ABIT_LAST) begin
                                mosi  <= 1'b0;
                                state <= TURN;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                                cmd_sr  <= cmd_shl;
                                mosi    <= cmd_shl[7];
                            end
                        end
                    end
                end

                TURN: begin
                    if (cyc_cnt == TURN_LAST) begin
                        cyc_cnt <= '0;
                        bit_cnt <= '0;
                        mosi    <= rw_q & wdata_sr[NBIT-1];
                        state   <= DATA;
                    end else begin
                        cyc_cnt <= cyc_cnt + 8'd1;
                    end
                end

                // Capture on the last clk of the low half, just before sclk rises.
                DATA: begin
                    if (!half_end) begin
                        cyc_cnt <= cyc_cnt + 8'd1;
                    end else begin
                        cyc_cnt <= '0;
                        if (!sclk) begin
                            sclk   <= 1'b1;
                            cap_sr <= cap_next;
                        end else begin
                            sclk <= 1'b0;
                            if (bit_cnt == DBIT_LAST) begin
                                mosi  <= 1'b0;
                                state <= HOLD;
                            end else begin
                                bit_cnt  <= bit_cnt + 5'd1;
                                wdata_sr <= wdata_shl;
                                mosi     <= rw_q & wdata_shl[NBIT-1];
                            end
                        end
                    end
                end

                HOLD: begin
                    if (half_end) begin
                        cyc_cnt <= '0;
                        cs      <= 1'b1;
                        done    <= 1'b1;
                        rdata   <= cap_sr;
                        state   <= GAP;
                    end else begin
                        cyc_cnt <= cyc_cnt + 8'd1;
                    end
                end

                GAP: begin
                    if (cyc_cnt == GAP_LAST) begin
                        cyc_cnt <= '0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        cyc_cnt <= cyc_cnt + 8'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
